tdc_readout_ctrl: RTL and testbench

Sequences the TDC measurement FIFO between its write (acquisition) phase and its read (UART dump) phase.
- During the write window it forwards timestamp words into the FIFO and flags overflow.
- On a read request it emits a framed packet to the UART transmitter byte by byte: sync byte, 16-bit word count, then every stored word MSB-first.
- Honours the transmitter handshake and CTS flow control, and flags FIFO underflow.

---
 rtl/tdc_readout_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_tdc_readout_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_readout_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tdc_readout_ctrl
//  Purpose  : Forwards TDC timestamps into the measurement FIFO during the
//             write window and dumps the FIFO as a framed byte packet
//             (sync, 16-bit count, words MSB-first) to a UART transmitter.
//  Revision : 1.0  initial release
// ============================================================================
module tdc_readout_ctrl #(
    parameter int         DATA_W    = 32,
    parameter int         CNT_W     = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_wr,
    input  logic              start_rd,
    input  logic              hit_valid,
    input  logic [DATA_W-1:0] hit_data,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    input  logic              cts,
    output logic              busy,
    output logic [CNT_W-1:0]  word_count,
    output logic              write_err,
    output logic              read_err
);

    localparam int c_BYTES  = DATA_W / 8;
    localparam int c_BIDX_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_HDR2 = 3'd3,
        S_POP  = 3'd4,
        S_LOAD = 3'd5,
        S_SEND = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_start_wr_d;
    logic                  r_start_rd_d;
    logic [CNT_W-1:0]      r_word_count;
    logic [CNT_W-1:0]      r_words_left;
    logic [DATA_W-1:0]     r_shift;
    logic [c_BIDX_W-1:0]   r_byte_idx;
    logic                  r_wr_en;
    logic [DATA_W-1:0]     r_wr_data;
    logic                  r_write_err;
    logic                  r_read_err;

    logic                  w_wr_rise;
    logic                  w_rd_rise;
    logic                  w_idle;
    logic                  w_hit_ok;
    logic                  w_hit_accept;
    logic                  w_tx_valid;
    logic                  w_xfer;
    logic                  w_last_byte;
    logic [15:0]           w_hdr_cnt;
    logic [7:0]            w_tx_data;
    logic                  w_rd_en;
    logic                  w_set_rd_err;
    logic                  w_clr_cnt;
    logic                  w_latch_cnt;

    assign w_wr_rise    = start_wr & ~r_start_wr_d;
    assign w_rd_rise    = start_rd & ~r_start_rd_d;
    assign w_idle       = (r_state == S_IDLE);
    assign w_hit_ok     = hit_valid & start_wr & w_idle;
    assign w_hit_accept = w_hit_ok & ~fifo_full;
    assign w_tx_valid   = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                          (r_state == S_HDR2) || (r_state == S_SEND);
    assign w_xfer       = w_tx_valid & tx_ready & cts;
    assign w_last_byte  = (r_byte_idx == c_BIDX_W'(c_BYTES - 1));
    // Header always carries two count bytes; narrower counters are zero-extended.
    assign w_hdr_cnt    = 16'(r_words_left);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and per-state controls.
    always_comb begin
        w_next       = r_state;
        w_tx_data    = 8'h00;
        w_rd_en      = 1'b0;
        w_set_rd_err = 1'b0;
        w_clr_cnt    = 1'b0;
        w_latch_cnt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A request during the write window is dropped, not queued.
                if (w_rd_rise && !start_wr) begin
                    w_next      = S_HDR0;
                    w_latch_cnt = 1'b1;
                end
            end
            S_HDR0: begin
                w_tx_data = SYNC_BYTE;
                if (w_xfer) w_next = S_HDR1;
            end
            S_HDR1: begin
                w_tx_data = w_hdr_cnt[15:8];
                if (w_xfer) w_next = S_HDR2;
            end
            S_HDR2: begin
                w_tx_data = w_hdr_cnt[7:0];
                if (w_xfer) begin
                    if (r_words_left == '0) begin
                        w_next = S_DONE;
                    end else if (fifo_empty) begin
                        w_set_rd_err = 1'b1;
                        w_next       = S_DONE;
                    end else begin
                        w_next = S_POP;
                    end
                end
            end
            S_POP: begin
                w_rd_en = 1'b1;
                w_next  = S_LOAD;
            end
            S_LOAD: begin
                w_next = S_SEND;
            end
            S_SEND: begin
                w_tx_data = r_shift[DATA_W-1 -: 8];
                if (w_xfer && w_last_byte) begin
                    if (r_words_left == '0) begin
                        w_next = S_DONE;
                    end else if (fifo_empty) begin
                        w_set_rd_err = 1'b1;
                        w_next       = S_DONE;
                    end else begin
                        w_next = S_POP;
                    end
                end
            end
            S_DONE: begin
                w_clr_cnt = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Edge detectors for the window/request levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_wr_d <= 1'b0;
            r_start_rd_d <= 1'b0;
        end else begin
            r_start_wr_d <= start_wr;
            r_start_rd_d <= start_rd;
        end
    end

    // Readout datapath: remaining-word counter, word shifter, byte index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_words_left <= '0;
            r_shift      <= '0;
            r_byte_idx   <= '0;
        end else begin
            if (w_latch_cnt) begin
                r_words_left <= r_word_count;
            end else if (w_rd_en) begin
                r_words_left <= r_words_left - 1'b1;
            end
            if (r_state == S_LOAD) begin
                r_shift    <= fifo_rd_data;
                r_byte_idx <= '0;
            end else if ((r_state == S_SEND) && w_xfer) begin
                r_shift    <= r_shift << 8;
                r_byte_idx <= r_byte_idx + 1'b1;
            end
        end
    end

    // Write path: one-cycle registered forward of accepted hits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_hit_accept;
            if (w_hit_accept) begin
                r_wr_data <= hit_data;
            end
        end
    end

    // Word counter and sticky error flags; a new write window starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_count <= '0;
            r_write_err  <= 1'b0;
            r_read_err   <= 1'b0;
        end else begin
            if (w_clr_cnt) begin
                r_word_count <= '0;
            end else if (w_wr_rise && w_idle) begin
                r_word_count <= w_hit_accept ? CNT_W'(1) : '0;
            end else if (w_hit_accept && (r_word_count != '1)) begin
                r_word_count <= r_word_count + 1'b1;
            end

            if (w_wr_rise && w_idle) begin
                r_write_err <= w_hit_ok & fifo_full;
                r_read_err  <= 1'b0;
            end else begin
                if (w_hit_ok && fifo_full) r_write_err <= 1'b1;
                if (w_set_rd_err)          r_read_err  <= 1'b1;
            end
        end
    end

    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_wr_data;
    assign fifo_rd_en   = w_rd_en;
    assign tx_valid     = w_tx_valid;
    assign tx_data      = w_tx_data;
    assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
    assign word_count   = r_word_count;
    assign write_err    = r_write_err;
    assign read_err     = r_read_err;

endmodule
`default_nettype wire

// File: tb/tb_tdc_readout_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdc_readout_ctrl
//  Purpose  : Directed self-checking bench for tdc_readout_ctrl with a
//             behavioural standard-read FIFO and a UART byte monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdc_readout_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_wr;
    logic        start_rd;
    logic        hit_valid;
    logic [31:0] hit_data;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        cts;
    logic        busy;
    logic [15:0] word_count;
    logic        write_err;
    logic        read_err;

    int n_checks = 0;
    int n_errors = 0;

    logic        store_en;
    logic        rand_rdy;
    logic [31:0] fifo_q[$];
    logic [7:0]  bytes_q[$];
    int          wr_pulses    = 0;
    int          rd_pulses    = 0;
    int          valid_cycles = 0;
    int          hold_viol    = 0;
    logic        prev_pend    = 1'b0;
    logic [7:0]  prev_data    = 8'h00;

    tdc_readout_ctrl #(
        .DATA_W   (32),
        .CNT_W    (16),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_wr    (start_wr),
        .start_rd    (start_rd),
        .hit_valid   (hit_valid),
        .hit_data    (hit_data),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .cts         (cts),
        .busy        (busy),
        .word_count  (word_count),
        .write_err   (write_err),
        .read_err    (read_err)
    );

    always #5 clk = ~clk;

    // FIFO model: acts on the falling edge, so read data is ready well
    // before the DUT samples it one cycle after fifo_rd_en.
    always @(negedge clk) begin
        if (rst) begin
            fifo_q.delete();
            fifo_rd_data = 32'h0;
        end else begin
            if (fifo_wr_en && store_en) fifo_q.push_back(fifo_wr_data);
            if (fifo_rd_en) begin
                if (fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
                else                   fifo_rd_data = 32'hBAD0BAD0;
            end
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    // UART monitor: captures transferred bytes and flags unstable offers.
    always @(negedge clk) begin
        if (rst) begin
            prev_pend = 1'b0;
        end else begin
            if (fifo_wr_en) wr_pulses++;
            if (fifo_rd_en) rd_pulses++;
            if (tx_valid)   valid_cycles++;
            if (prev_pend && (!tx_valid || tx_data != prev_data)) hold_viol++;
            if (tx_valid && tx_ready && cts) bytes_q.push_back(tx_data);
            prev_pend = tx_valid && !(tx_ready && cts);
            prev_data = tx_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic send_hit(input logic [31:0] d);
        hit_valid = 1'b1;
        hit_data  = d;
        step();
        hit_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            step();
        end
        check_eq("idle_timeout", {31'b0, busy}, 32'd0);
        step();
        step();
    endtask

    task automatic do_read();
        start_rd = 1'b1;
        step();
        start_rd = 1'b0;
        wait_idle();
    endtask

    task automatic check_pkt(input string tag, input int start, input logic [7:0] exp[$]);
        logic [7:0] got_b;
        check_eq({tag, "_len"}, 32'(bytes_q.size() - start), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            got_b = (start + i < bytes_q.size()) ? bytes_q[start + i] : 8'hxx;
            check_eq($sformatf("%s_b%0d", tag, i), {24'b0, got_b}, {24'b0, exp[i]});
        end
    endtask

    initial begin
        int          pkt;
        int          snap;
        int          vsnap;
        logic [7:0]  exp[$];

        rst = 1'b1; start_wr = 1'b0; start_rd = 1'b0; hit_valid = 1'b0;
        hit_data = 32'h0; fifo_full = 1'b0; tx_ready = 1'b1; cts = 1'b1;
        store_en = 1'b1; rand_rdy = 1'b0;
        repeat (3) step();
        check_eq("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_word_count", {16'b0, word_count}, 32'd0);
        check_eq("rst_errs", {30'b0, write_err, read_err}, 32'd0);
        rst = 1'b0;
        step();

        // 1: three hits then a full readout, with a random tx_ready.
        rand_rdy = 1'b1;
        snap = wr_pulses;
        start_wr = 1'b1;
        step();
        send_hit(32'h11223344);
        send_hit(32'h55667788);
        send_hit(32'h0000ABCD);
        check_eq("t1_word_count", {16'b0, word_count}, 32'd3);
        step();
        step();
        check_eq("t1_wr_pulses", 32'(wr_pulses - snap), 32'd3);
        start_wr = 1'b0;
        step();
        pkt = bytes_q.size();
        do_read();
        exp = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 8'h00, 8'hAB, 8'hCD};
        check_pkt("t1_pkt", pkt, exp);
        check_eq("t1_word_count_after", {16'b0, word_count}, 32'd0);
        check_eq("t1_errs", {30'b0, write_err, read_err}, 32'd0);
        rand_rdy = 1'b0;

        // 2: overflow sets write_err, next window clears it.
        start_wr = 1'b1;
        step();
        snap = wr_pulses;
        fifo_full = 1'b1;
        send_hit(32'hFFFF0000);
        fifo_full = 1'b0;
        check_eq("t2_write_err", {31'b0, write_err}, 32'd1);
        check_eq("t2_word_count", {16'b0, word_count}, 32'd0);
        step();
        step();
        check_eq("t2_no_wr_pulse", 32'(wr_pulses - snap), 32'd0);
        start_wr = 1'b0;
        step();
        start_wr = 1'b1;
        step();
        check_eq("t2_write_err_clr", {31'b0, write_err}, 32'd0);

        // 3: count says two words but the FIFO only holds one.
        rand_rdy = 1'b1;
        send_hit(32'hDEADBEEF);
        step();
        store_en = 1'b0;
        send_hit(32'hCAFEF00D);
        step();
        step();
        store_en = 1'b1;
        check_eq("t3_word_count", {16'b0, word_count}, 32'd2);
        start_wr = 1'b0;
        step();
        pkt  = bytes_q.size();
        snap = rd_pulses;
        do_read();
        exp = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        check_pkt("t3_pkt", pkt, exp);
        check_eq("t3_read_err", {31'b0, read_err}, 32'd1);
        check_eq("t3_rd_pulses", 32'(rd_pulses - snap), 32'd1);
        check_eq("t3_busy", {31'b0, busy}, 32'd0);
        rand_rdy = 1'b0;

        // 4: cts stall on the second header byte.
        start_wr = 1'b1;
        step();
        check_eq("t4_read_err_clr", {31'b0, read_err}, 32'd0);
        send_hit(32'h01020304);
        step();
        start_wr = 1'b0;
        step();
        pkt = bytes_q.size();
        start_rd = 1'b1;
        step();
        start_rd = 1'b0;
        check_eq("t4_hdr0_valid", {31'b0, tx_valid}, 32'd1);
        step();
        cts = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_eq("t4_stall_valid", {31'b0, tx_valid}, 32'd1);
            check_eq("t4_stall_data", {24'b0, tx_data}, 32'h00);
            step();
        end
        cts = 1'b1;
        wait_idle();
        exp = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        check_pkt("t4_pkt", pkt, exp);

        // 5: request during write window is ignored; then empty readout.
        start_wr = 1'b1;
        step();
        vsnap = valid_cycles;
        start_rd = 1'b1;
        step();
        start_rd = 1'b0;
        step();
        step();
        check_eq("t5_ignored_busy", {31'b0, busy}, 32'd0);
        check_eq("t5_ignored_valid", 32'(valid_cycles - vsnap), 32'd0);
        start_wr = 1'b0;
        step();
        pkt  = bytes_q.size();
        snap = rd_pulses;
        do_read();
        exp = '{8'hA5, 8'h00, 8'h00};
        check_pkt("t5_pkt", pkt, exp);
        check_eq("t5_rd_pulses", 32'(rd_pulses - snap), 32'd0);

        // 6: reset in the middle of the data bytes.
        start_wr = 1'b1;
        step();
        send_hit(32'h89ABCDEF);
        step();
        start_wr = 1'b0;
        step();
        pkt = bytes_q.size();
        start_rd = 1'b1;
        step();
        start_rd = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bytes_q.size() >= pkt + 4) break;
            step();
        end
        check_eq("t6_reach_send", 32'(bytes_q.size() - pkt), 32'd4);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_valid", {31'b0, tx_valid}, 32'd0);
        check_eq("t6_rst_data", {24'b0, tx_data}, 32'd0);
        check_eq("t6_rst_busy", {31'b0, busy}, 32'd0);
        check_eq("t6_rst_count", {16'b0, word_count}, 32'd0);
        check_eq("t6_rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        step();
        rst = 1'b0;
        vsnap = valid_cycles;
        repeat (6) step();
        check_eq("t6_quiet", 32'(valid_cycles - vsnap), 32'd0);
        pkt = bytes_q.size();
        do_read();
        exp = '{8'hA5, 8'h00, 8'h00};
        check_pkt("t6_pkt", pkt, exp);

        check_eq("tx_hold_violations", 32'(hold_viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
